// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the CPU input peripheral.
//   WORD_W_DEFAULT   - default width of the switch word
//   debounce_state_t - states of the enter-button debounce FSM
package cpu_pkg;

    localparam int unsigned WORD_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } debounce_state_t;

endpackage : cpu_pkg

// File: rtl/cpu_input_port_sync_bit.sv
// sync_bit: multi-flop synchroniser for one asynchronous input bit.
//   i_clock - system clock
//   i_reset - synchronous active-high reset, clears every stage
//   i_d     - raw asynchronous input
//   o_q     - synchronised output (last stage)
module sync_bit #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule : sync_bit

// File: rtl/cpu_input_port.sv
// cpu_input_port: switch-word input peripheral for the 8-bit CPU.
// Synchronises the switches and the enter button, debounces the button and
// captures one switch word per clean press into a holding register.
//   clock      - system clock, rising edge
//   reset      - synchronous active-high reset
//   switches   - raw switch levels
//   enter      - raw pushbutton, 1 = pressed
//   rd_en      - one-clock CPU read strobe
//   data_out   - holding register
//   data_valid - unread word present
//   overrun    - sticky: a word was overwritten before being read
//   busy       - debounce FSM not idle
module cpu_input_port
    import cpu_pkg::*;
#(
    parameter int unsigned WORD_W          = WORD_W_DEFAULT,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WORD_W-1:0] switches,
    input  logic              enter,
    input  logic              rd_en,
    output logic [WORD_W-1:0] data_out,
    output logic              data_valid,
    output logic              overrun,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WORD_W-1:0] w_sw_s;
    logic              w_enter_s;

    sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_enter (
        .i_clock (clock),
        .i_reset (reset),
        .i_d     (enter),
        .o_q     (w_enter_s)
    );

    for (genvar g = 0; g < WORD_W; g++) begin : g_sync_sw
        sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sw (
            .i_clock (clock),
            .i_reset (reset),
            .i_d     (switches[g]),
            .o_q     (w_sw_s[g])
        );
    end

    debounce_state_t   r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_enter_q;
    logic              r_busy;
    logic [WORD_W-1:0] r_data;
    logic              r_valid;
    logic              r_overrun;
    logic              w_capture;
    logic              w_read;

    // The FSM acts on a registered copy of the synchronised button; this
    // extra sample sets the press-to-valid latency at
    // SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_enter_q) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            PRESS_WAIT: begin
                if (!r_enter_q) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = PRESSED;
                    w_capture   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!r_enter_q) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            RELEASE_WAIT: begin
                if (r_enter_q) begin
                    w_state_nxt = PRESSED;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_read = rd_en && r_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_enter_q <= 1'b0;
            r_busy    <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_enter_q <= w_enter_s;
            r_busy    <= (w_state_nxt != IDLE);
            if (w_capture) begin
                r_data  <= w_sw_s;
                r_valid <= 1'b1;
                // A read on the capture edge consumes the old word, so the
                // new one is not an overrun.
                if (w_read) begin
                    r_overrun <= 1'b0;
                end else if (r_valid) begin
                    r_overrun <= 1'b1;
                end
            end else if (w_read) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign overrun    = r_overrun;
    assign busy       = r_busy;

endmodule : cpu_input_port

// File: tb/tb_cpu_input_port.sv
module tb_cpu_input_port;

    localparam int unsigned WORD_W = 8;
    localparam int unsigned SYNC   = 2;
    localparam int unsigned DEB    = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [WORD_W-1:0] switches = '0;
    logic              enter = 1'b0;
    logic              rd_en = 1'b0;
    logic [WORD_W-1:0] data_out;
    logic              data_valid;
    logic              overrun;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    cpu_input_port #(
        .WORD_W          (WORD_W),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .switches   (switches),
        .enter      (enter),
        .rd_en      (rd_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // Reference model: the button level the logic acts on is the raw level
    // from SYNC+1 edges earlier, the switch word from SYNC edges earlier.
    // The debounced level flips once DEB consecutive samples disagree with it;
    // a flip to 1 is a press and captures the word.
    logic              m_ep [SYNC+1];
    logic [WORD_W-1:0] m_sp [SYNC];
    logic              m_level = 1'b0;
    int                m_run = 0;
    logic [WORD_W-1:0] m_data = '0;
    logic              m_valid = 1'b0;
    logic              m_ovr = 1'b0;
    logic              m_busy = 1'b0;
    bit                cyc_check = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i <= SYNC; i++) m_ep[i] = 1'b0;
        for (int i = 0; i < SYNC; i++) m_sp[i] = '0;
        m_level = 1'b0;
        m_run   = 0;
        m_data  = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_busy  = 1'b0;
    endtask

    task automatic tick();
        logic              d;
        logic [WORD_W-1:0] sw;
        bit                press;
        @(posedge clock);
        if (reset) begin
            model_reset();
        end else begin
            d  = m_ep[SYNC];
            sw = m_sp[SYNC-1];
            for (int i = SYNC; i > 0; i--) m_ep[i] = m_ep[i-1];
            m_ep[0] = enter;
            for (int i = SYNC - 1; i > 0; i--) m_sp[i] = m_sp[i-1];
            m_sp[0] = switches;
            press = 1'b0;
            if (d != m_level) begin
                m_run++;
                if (m_run == DEB) begin
                    m_level = d;
                    m_run   = 0;
                    press   = d;
                end
            end else begin
                m_run = 0;
            end
            if (press) begin
                if (m_valid && rd_en) m_ovr = 1'b0;
                else if (m_valid)     m_ovr = 1'b1;
                m_data  = sw;
                m_valid = 1'b1;
            end else if (rd_en && m_valid) begin
                m_valid = 1'b0;
                m_ovr   = 1'b0;
            end
            m_busy = m_level || d;
        end
        #1;
        if (cyc_check) begin
            check("cyc_data", 32'(data_out), 32'(m_data));
            check("cyc_valid", 32'(data_valid), 32'(m_valid));
            check("cyc_overrun", 32'(overrun), 32'(m_ovr));
            check("cyc_busy", 32'(busy), 32'(m_busy));
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input logic [WORD_W-1:0] val);
        switches = val;
        enter    = 1'b1;
        ticks(10);
        enter = 1'b0;
        ticks(8);
    endtask

    task automatic read_pulse();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        int captures;
        logic prev_valid;
        int hold;

        model_reset();

        // 1. reset with inputs active
        reset    = 1'b1;
        switches = 8'hFF;
        enter    = 1'b1;
        ticks(2);
        check("rst_data", 32'(data_out), 32'h00);
        check("rst_valid", 32'(data_valid), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // 2. clean press held for 20 clocks
        reset    = 1'b0;
        switches = 8'h5A;
        captures = 0;
        prev_valid = data_valid;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 6) check("lat_not_yet", 32'(data_valid), 32'h0);
            if (i == 7) begin
                check("lat_valid", 32'(data_valid), 32'h1);
                check("lat_data", 32'(data_out), 32'h5A);
            end
            if (data_valid && !prev_valid) captures++;
            prev_valid = data_valid;
        end
        check("one_capture", 32'(captures), 32'd1);
        check("held_busy", 32'(busy), 32'h1);
        enter = 1'b0;
        ticks(8);
        check("release_busy", 32'(busy), 32'h0);

        // 4. read handshake, then a read with nothing pending
        read_pulse();
        check("read_valid", 32'(data_valid), 32'h0);
        check("read_data", 32'(data_out), 32'h5A);
        read_pulse();
        check("read2_valid", 32'(data_valid), 32'h0);
        check("read2_overrun", 32'(overrun), 32'h0);
        check("read2_data", 32'(data_out), 32'h5A);

        // 3. bounce rejection
        switches = 8'hC3;
        enter = 1'b1; tick();
        enter = 1'b1; tick();
        enter = 1'b0; tick();
        enter = 1'b1; tick();
        enter = 1'b0; tick();
        ticks(8);
        check("bounce_valid", 32'(data_valid), 32'h0);
        check("bounce_busy", 32'(busy), 32'h0);
        check("bounce_data", 32'(data_out), 32'h5A);

        // 5. overrun
        press(8'h11);
        press(8'h22);
        check("ovr_data", 32'(data_out), 32'h22);
        check("ovr_valid", 32'(data_valid), 32'h1);
        check("ovr_flag", 32'(overrun), 32'h1);
        read_pulse();
        check("ovr_clr_valid", 32'(data_valid), 32'h0);
        check("ovr_clr_flag", 32'(overrun), 32'h0);

        // 6a. read on the capture edge while an old word is pending
        press(8'h44);
        switches = 8'h33;
        enter    = 1'b1;
        ticks(6);
        check("coll_old", 32'(data_out), 32'h44);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("coll_valid", 32'(data_valid), 32'h1);
        check("coll_overrun", 32'(overrun), 32'h0);
        check("coll_data", 32'(data_out), 32'h33);
        ticks(3);
        enter = 1'b0;
        ticks(8);

        // 6b. reset in PRESS_WAIT, button held through and after reset
        read_pulse();
        switches = 8'h66;
        enter    = 1'b1;
        ticks(4);
        check("pw_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        tick();
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_data", 32'(data_out), 32'h00);
        reset = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 6) check("rst_hold_wait", 32'(data_valid), 32'h0);
            if (i == 7) begin
                check("rst_hold_valid", 32'(data_valid), 32'h1);
                check("rst_hold_data", 32'(data_out), 32'h66);
            end
        end
        enter = 1'b0;
        ticks(8);

        // randomized traffic against the model
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                enter = ~enter;
                hold  = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 14) : $urandom_range(1, 4);
            end
            hold--;
            if ($urandom_range(0, 2) == 0) switches = WORD_W'($urandom);
            rd_en = ($urandom_range(0, 5) == 0);
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        rd_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_cpu_input_port
